spm_mem_responder: RTL and testbench
====================================

SPM_MEM_RESPONDER -- requirements
Module: spm_mem_responder

Interface
REQ-001 Parameter word_size, default 8: data and address width.
REQ-002 Parameter fifo_depth, default 4: output FIFO entries, power of two.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 address  input  word_size  processor address register value.
REQ-006 data_in  input  word_size  processor write data (bus_1).
REQ-007 write  input  1  processor write strobe, active high, sampled at posedge clk.
REQ-008 data_out  output  word_size  read data to processor (mem_word).
REQ-009 out_data  output  word_size  FIFO head byte to external sink.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  sink accepts head when out_valid & out_ready at posedge.
REQ-012 in_data  input  word_size  external source byte.
REQ-013 in_valid  input  1  source byte present.
REQ-014 in_ready  output  1  responder can capture in_data; equals ~in_full.

Function
REQ-015 Address map SHALL be: 0x00-0xEF RAM; 0xF0 OUT; 0xF1 IN; 0xF2 STATUS; 0xF3 TIMER; 0xF4-0xFF reserved.
REQ-016 data_out SHALL be combinational from address and current register/RAM state (zero-cycle read latency); reads have no side effects.
REQ-017 RAM write SHALL occur at posedge clk when write=1 and address<=0xEF; new value is visible on data_out the next cycle.
REQ-018 Reading OUT SHALL return FIFO count (0..fifo_depth), zero-extended.
REQ-019 Writing OUT SHALL push data_in; when full and no pop that cycle, the push is dropped and sticky overflow is set.
REQ-020 Simultaneous push and pop SHALL both take effect, count unchanged, including when full; pop on empty is impossible (out_valid=0).
REQ-021 FIFO pointers SHALL wrap modulo fifo_depth; ordering strictly first-in first-out.
REQ-022 Capture SHALL occur when in_valid & in_ready: in_hold<=in_data, in_full<=1; reading IN returns in_hold.
REQ-023 STATUS read: bit0 in_full, bit1 fifo_full, bit2 fifo_empty, bit3 timer_expired, bit4 overflow, bits7:5 zero.
REQ-024 STATUS write: a 1 in bit0/bit3/bit4 clears in_full/timer_expired/overflow; zeros no effect; clear and same-cycle set -> set wins.
REQ-025 TIMER write SHALL load reload and count with data_in; writing 0 stops the timer.
REQ-026 When reload!=0, count SHALL decrement each cycle; on count==1 it reloads and sets timer_expired (period = reload cycles).
REQ-027 Reading TIMER SHALL return current count.
REQ-028 Reserved addresses SHALL read 0; writes ignored.

Reset
REQ-029 On rst=0, asynchronously: FIFO pointers/count 0, in_hold 0, in_full 0, overflow 0, timer_expired 0, reload 0, count 0; hence out_valid=0, out_data=0, in_ready=1.
REQ-030 RAM contents SHALL NOT be reset; undefined until written.
REQ-031 Reset mid-transfer SHALL discard FIFO contents and held input without completing any handshake.

Structure
REQ-032 Address constants (0xEF boundary, 0xF0-0xF3) and STATUS bit positions SHALL live in the shared constants package used by the SPM processor and controller.
REQ-033 The output FIFO SHALL be a sub-module spm_io_fifo (push, pop, din, dout, count, full, empty).

Verification
REQ-034 Write 0x5A to 0x10, then read 0x10 -> data_out=0x5A next cycle; read 0xF8 -> 0x00.
REQ-035 Out_ready=0, write 0x01..0x05 to 0xF0 -> OUT reads 4, STATUS=0x12; raise out_ready -> out_data 0x01,0x02,0x03,0x04 then out_valid=0.
REQ-036 FIFO full, out_ready=1, write 0x77 same cycle -> count stays 4, overflow stays 0, 0x77 emerges last.
REQ-037 in_data=0xA3, in_valid=1 -> in_ready drops next cycle, IN reads 0xA3; write 0x01 to STATUS -> in_ready=1.
REQ-038 Write 0x03 to TIMER -> timer_expired set every 3 cycles; write 0x00 -> count frozen at 0, no further sets.
REQ-039 Assert rst low with 3 FIFO entries and in_full=1 -> out_valid=0, in_ready=1, STATUS=0x04 immediately.

Source files
------------

// File: rtl/spm_mem_responder_pkg.sv
// Shared SPM memory-map constants: RAM/IO address boundaries, STATUS bit
// positions and the address-region decoder used by the processor side.
package spm_mem_responder_pkg;

    localparam logic [7:0] ADDR_RAM_TOP = 8'hEF;
    localparam logic [7:0] ADDR_OUT     = 8'hF0;
    localparam logic [7:0] ADDR_IN      = 8'hF1;
    localparam logic [7:0] ADDR_STATUS  = 8'hF2;
    localparam logic [7:0] ADDR_TIMER   = 8'hF3;

    localparam int RAM_WORDS = 240;

    localparam int STAT_IN_FULL    = 0;
    localparam int STAT_FIFO_FULL  = 1;
    localparam int STAT_FIFO_EMPTY = 2;
    localparam int STAT_TIMER_EXP  = 3;
    localparam int STAT_OVERFLOW   = 4;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_OUT,
        REGION_IN,
        REGION_STATUS,
        REGION_TIMER,
        REGION_RESERVED
    } region_t;

    // Everything above the RAM window that is not a named register is reserved.
    function automatic region_t decode_region(input logic [7:0] addr);
        region_t r;
        if (addr <= ADDR_RAM_TOP) begin
            r = REGION_RAM;
        end else begin
            case (addr)
                ADDR_OUT:    r = REGION_OUT;
                ADDR_IN:     r = REGION_IN;
                ADDR_STATUS: r = REGION_STATUS;
                ADDR_TIMER:  r = REGION_TIMER;
                default:     r = REGION_RESERVED;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/spm_io_fifo.sv
// Output FIFO between the processor OUT register and the external sink.
// depth must be a power of two so the pointers wrap by plain overflow.
module spm_io_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [width-1:0] mem [0:depth-1];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(depth));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spm_mem_responder.sv
// Memory responder for the SPM processor: RAM window plus OUT FIFO, IN
// holding register, STATUS flags and a reloading interval timer.
module spm_mem_responder
    import spm_mem_responder_pkg::*;
#(
    parameter int word_size  = 8,
    parameter int fifo_depth = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] address,
    input  logic [word_size-1:0] data_in,
    input  logic                 write,
    output logic [word_size-1:0] data_out,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready
);

    localparam int CW = $clog2(fifo_depth) + 1;

    logic [word_size-1:0] ram [0:RAM_WORDS-1];

    region_t              region;
    logic                 ram_wr;
    logic                 push;
    logic                 pop;
    logic                 status_wr;
    logic                 timer_wr;
    logic                 capture;
    logic                 timer_tick;
    logic                 overflow_set;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [word_size-1:0] fifo_dout;
    logic [word_size-1:0] in_hold;
    logic                 in_full;
    logic                 overflow;
    logic                 timer_expired;
    logic [word_size-1:0] reload;
    logic [word_size-1:0] timer_count;
    logic [7:0]           status_bits;

    // Decoding uses the low byte; the map is defined for an 8-bit address space.
    assign region    = decode_region(address[7:0]);
    assign ram_wr    = write & (region == REGION_RAM);
    assign push      = write & (region == REGION_OUT);
    assign status_wr = write & (region == REGION_STATUS);
    assign timer_wr  = write & (region == REGION_TIMER);

    assign out_valid    = ~fifo_empty;
    assign out_data     = fifo_dout;
    assign pop          = out_valid & out_ready;
    assign in_ready     = ~in_full;
    assign capture      = in_valid & in_ready;
    assign overflow_set = push & fifo_full & ~pop;
    assign timer_tick   = ~timer_wr & (reload != '0) & (timer_count == word_size'(1));

    spm_io_fifo #(
        .width (word_size),
        .depth (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            ram[address[7:0]] <= data_in;
        end
    end

    // Flag sets take priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_hold       <= '0;
            in_full       <= 1'b0;
            overflow      <= 1'b0;
            timer_expired <= 1'b0;
        end else begin
            if (capture) begin
                in_hold <= in_data;
            end
            in_full       <= capture |
                             (in_full & ~(status_wr & data_in[STAT_IN_FULL]));
            overflow      <= overflow_set |
                             (overflow & ~(status_wr & data_in[STAT_OVERFLOW]));
            timer_expired <= timer_tick |
                             (timer_expired & ~(status_wr & data_in[STAT_TIMER_EXP]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload      <= '0;
            timer_count <= '0;
        end else if (timer_wr) begin
            reload      <= data_in;
            timer_count <= data_in;
        end else if (reload != '0) begin
            if (timer_count == word_size'(1)) begin
                timer_count <= reload;
            end else begin
                timer_count <= timer_count - word_size'(1);
            end
        end
    end

    always_comb begin
        status_bits                  = '0;
        status_bits[STAT_IN_FULL]    = in_full;
        status_bits[STAT_FIFO_FULL]  = fifo_full;
        status_bits[STAT_FIFO_EMPTY] = fifo_empty;
        status_bits[STAT_TIMER_EXP]  = timer_expired;
        status_bits[STAT_OVERFLOW]   = overflow;
    end

    always_comb begin
        data_out = '0;
        case (region)
            REGION_RAM:    data_out = ram[address[7:0]];
            REGION_OUT:    data_out = word_size'(fifo_count);
            REGION_IN:     data_out = in_hold;
            REGION_STATUS: data_out = word_size'(status_bits);
            REGION_TIMER:  data_out = timer_count;
            default:       data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_spm_mem_responder.sv
// Self-checking bench for spm_mem_responder: directed scenarios followed by
// randomized traffic compared against a queue/array reference model.
module tb_spm_mem_responder;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] address;
    logic [7:0] data_in;
    logic       write;
    logic [7:0] data_out;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    int n_checks;
    int n_fail;

    logic [7:0] q[$];
    logic [7:0] ram_m [0:239];
    bit         ram_v [0:239];
    logic       m_in_full;
    logic [7:0] m_in_hold;
    logic       m_ovf;
    logic       m_exp;
    logic [7:0] m_reload;
    int         m_n;

    spm_mem_responder #(
        .word_size  (8),
        .fifo_depth (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .data_in   (data_in),
        .write     (write),
        .data_out  (data_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        write   = 1'b1;
        @(posedge clk);
        #1;
        write   = 1'b0;
    endtask

    // Timer count derived from cycles elapsed since the last TIMER load.
    function automatic logic [7:0] model_timer();
        if (m_reload == 8'h00) return 8'h00;
        return 8'(int'(m_reload) - (m_n % int'(m_reload)));
    endfunction

    function automatic logic [7:0] model_read(input logic [7:0] a);
        logic [7:0] s;
        if (a <= 8'hEF) return ram_m[a];
        case (a)
            8'hF0: return 8'(q.size());
            8'hF1: return m_in_hold;
            8'hF2: begin
                s = {3'b000, m_ovf, m_exp, (q.size() == 0), (q.size() == DEPTH), m_in_full};
                return s;
            end
            8'hF3: return model_timer();
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_reset();
        rst       = 1'b0;
        address   = 8'hF2;
        data_in   = 8'h00;
        write     = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h ready=%b, expected 0 00 1",
                     out_valid, out_data, in_ready);
        end
        n_checks++;
        if (data_out !== 8'h04) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got %h expected 04", data_out);
        end
        address = 8'hF3;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_timer: got %h expected 00", data_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_ram();
        bus_write(8'h10, 8'h5A);
        bus_write(8'hEF, 8'hC3);
        bus_write(8'hF8, 8'hFF);
        address = 8'h10;
        #1;
        n_checks++;
        if (data_out !== 8'h5A) begin
            n_fail++;
            $display("[TB] FAIL ram_read_10: got %h expected 5a", data_out);
        end
        address = 8'hEF;
        #1;
        n_checks++;
        if (data_out !== 8'hC3) begin
            n_fail++;
            $display("[TB] FAIL ram_read_ef: got %h expected c3", data_out);
        end
        address = 8'hF8;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reserved_read_f8: got %h expected 00", data_out);
        end
    endtask

    task automatic test_fifo_fill_drain();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) bus_write(8'hF0, 8'(i));
        address = 8'hF0;
        #1;
        n_checks++;
        if (data_out !== 8'h04) begin
            n_fail++;
            $display("[TB] FAIL fifo_count_full: got %h expected 04", data_out);
        end
        address = 8'hF2;
        #1;
        n_checks++;
        if (data_out !== 8'h12) begin
            n_fail++;
            $display("[TB] FAIL status_full_ovf: got %h expected 12", data_out);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL drain_%0d: got valid=%b data=%h expected 1 %h",
                         i, out_valid, out_data, 8'(i));
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL drain_empty: got valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
        bus_write(8'hF2, 8'h10);
        address = 8'hF2;
        #1;
        n_checks++;
        if (data_out !== 8'h04) begin
            n_fail++;
            $display("[TB] FAIL ovf_clear: got %h expected 04", data_out);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h12;
        exp_seq[1] = 8'h13;
        exp_seq[2] = 8'h14;
        exp_seq[3] = 8'h77;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(8'hF0, 8'(8'h11 + i));
        @(negedge clk);
        address   = 8'hF0;
        data_in   = 8'h77;
        write     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        write     = 1'b0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 8'h04) begin
            n_fail++;
            $display("[TB] FAIL pushpop_count: got %h expected 04", data_out);
        end
        address = 8'hF2;
        #1;
        n_checks++;
        if (data_out !== 8'h02) begin
            n_fail++;
            $display("[TB] FAIL pushpop_status: got %h expected 02", data_out);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin
                n_fail++;
                $display("[TB] FAIL pushpop_order_%0d: got valid=%b data=%h expected 1 %h",
                         i, out_valid, out_data, exp_seq[i]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pushpop_empty: got valid=%b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_input_capture();
        @(negedge clk);
        in_data  = 8'hA3;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL in_ready_idle: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_data = 8'h55;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        address  = 8'hF1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || data_out !== 8'hA3) begin
            n_fail++;
            $display("[TB] FAIL capture_hold: got ready=%b in=%h expected 0 a3", in_ready, data_out);
        end
        address = 8'hF2;
        #1;
        n_checks++;
        if (data_out !== 8'h05) begin
            n_fail++;
            $display("[TB] FAIL capture_status: got %h expected 05", data_out);
        end
        bus_write(8'hF2, 8'h01);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL in_full_clear: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_timer();
        logic [7:0] exp_cnt;
        logic       exp_exp;
        bus_write(8'hF3, 8'h03);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k % 3 == 2) begin
                address = 8'hF2;
                data_in = 8'h08;
                write   = 1'b1;
            end
            @(posedge clk);
            #1;
            write   = 1'b0;
            exp_cnt = 8'(3 - (k % 3));
            exp_exp = (k >= 3) && (k % 3 != 2);
            address = 8'hF3;
            #1;
            n_checks++;
            if (data_out !== exp_cnt) begin
                n_fail++;
                $display("[TB] FAIL timer_count_%0d: got %h expected %h", k, data_out, exp_cnt);
            end
            address = 8'hF2;
            #1;
            n_checks++;
            if (data_out[3] !== exp_exp) begin
                n_fail++;
                $display("[TB] FAIL timer_expired_%0d: got %b expected %b", k, data_out[3], exp_exp);
            end
        end
        bus_write(8'hF3, 8'h00);
        bus_write(8'hF2, 8'h08);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            address = 8'hF3;
            #1;
            n_checks++;
            if (data_out !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL timer_stopped_%0d: got %h expected 00", k, data_out);
            end
            address = 8'hF2;
            #1;
            n_checks++;
            if (data_out[3] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL timer_noset_%0d: got %b expected 0", k, data_out[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(8'hF0, 8'(8'h60 + i));
        @(negedge clk);
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        address  = 8'hF2;
        #1;
        n_checks++;
        if (data_out !== 8'h01) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_status: got %h expected 01", data_out);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 8'h04 || out_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset: got valid=%b ready=%b status=%h data=%h expected 0 1 04 00",
                     out_valid, in_ready, data_out, out_data);
        end
        address = 8'hF1;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_in_hold: got %h expected 00", data_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] exp_rd;
        int         sel;
        bit         do_pop;
        bit         do_push;
        bit         st_wr;
        bit         tm_wr;
        bit         cap;
        bit         exp_set;
        bit         ovf_set;
        @(negedge clk);
        rst = 1'b0;
        write = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 240; i++) ram_v[i] = 1'b0;
        m_in_full = 1'b0;
        m_in_hold = 8'h00;
        m_ovf     = 1'b0;
        m_exp     = 1'b0;
        m_reload  = 8'h00;
        m_n       = 0;
        #2;
        rst = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            sel = $urandom_range(0, 11);
            case (sel)
                0, 1, 2: address = 8'($urandom_range(0, 15));
                3:       address = 8'hEF;
                4, 5, 6: address = 8'hF0;
                7:       address = 8'hF1;
                8, 9:    address = 8'hF2;
                10:      address = 8'hF3;
                default: address = 8'($urandom_range(8'hF4, 8'hFF));
            endcase
            write     = ($urandom_range(0, 1) == 1);
            data_in   = (address == 8'hF3) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            #1;
            n_checks++;
            if (out_valid !== (q.size() != 0) || out_data !== ((q.size() != 0) ? q[0] : 8'h00)
                || in_ready !== !m_in_full) begin
                n_fail++;
                $display("[TB] FAIL rand_io_%0d: got valid=%b data=%h ready=%b expected %b %h %b",
                         cyc, out_valid, out_data, in_ready, (q.size() != 0),
                         (q.size() != 0) ? q[0] : 8'h00, !m_in_full);
            end
            if (address > 8'hEF || ram_v[address]) begin
                exp_rd = model_read(address);
                n_checks++;
                if (data_out !== exp_rd) begin
                    n_fail++;
                    $display("[TB] FAIL rand_read_%0d addr=%h: got %h expected %h",
                             cyc, address, data_out, exp_rd);
                end
            end
            @(posedge clk);
            do_pop  = (q.size() != 0) && out_ready;
            do_push = write && (address == 8'hF0);
            st_wr   = write && (address == 8'hF2);
            tm_wr   = write && (address == 8'hF3);
            cap     = in_valid && !m_in_full;
            exp_set = !tm_wr && (m_reload != 8'h00) && ((m_n + 1) % int'(m_reload) == 0);
            ovf_set = do_push && (q.size() == DEPTH) && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (do_push && q.size() < DEPTH) q.push_back(data_in);
            if (write && address <= 8'hEF) begin
                ram_m[address] = data_in;
                ram_v[address] = 1'b1;
            end
            if (st_wr) begin
                if (data_in[0]) m_in_full = 1'b0;
                if (data_in[3]) m_exp = 1'b0;
                if (data_in[4]) m_ovf = 1'b0;
            end
            if (cap) begin
                m_in_full = 1'b1;
                m_in_hold = in_data;
            end
            if (exp_set) m_exp = 1'b1;
            if (ovf_set) m_ovf = 1'b1;
            if (tm_wr) begin
                m_reload = data_in;
                m_n      = 0;
            end else if (m_reload != 8'h00) begin
                m_n++;
            end
        end
        #1;
        write    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ram();
        test_fifo_fill_drain();
        test_full_push_pop();
        test_input_capture();
        test_timer();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
